// File: rtl/dot8_compute_engine.sv
// Compute-side responder: fetches A and B vectors from the operand memory read port,
// accumulates their unsigned dot product and returns a clamped/truncated result.
module dot8_compute_engine #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned N_ELEM   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned B_BASE   = 8,
   parameter int unsigned SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode_compute,
   input  logic              comp_start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy,
   output logic              comp_done,
   output logic [DATA_W-1:0] comp_result,
   output logic              comp_ovf
);

   localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_ELEM);
   localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(N_ELEM - 1);
   localparam logic [ADDR_W-1:0] BBase   = ADDR_W'(B_BASE);
   localparam logic [ACC_W-1:0]  DataMax = ACC_W'((64'd1 << DATA_W) - 64'd1);

   typedef enum logic [2:0] {StIdle, StFetchA, StFetchB, StMac, StDone} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                ovf_q, ovf_d;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    acc_sum;
   logic                sum_ovf;

   // Accumulator is wide enough for N_ELEM full-scale products, so it never wraps.
   assign prod    = (2*DATA_W)'(a_q) * (2*DATA_W)'(mem_rd_data);
   assign acc_sum = acc_q + ACC_W'(prod);
   assign sum_ovf = (acc_sum > DataMax);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      a_d         = a_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      comp_done   = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (comp_start && mode_compute) begin
               state_d = StFetchA;
               idx_d   = '0;
               acc_d   = '0;
               a_d     = '0;
            end
         end
         StFetchA: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = ADDR_W'(idx_q);
            state_d     = StFetchB;
         end
         StFetchB: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = BBase + ADDR_W'(idx_q);
            a_d         = mem_rd_data;
            state_d     = StMac;
         end
         StMac: begin
            acc_d = acc_sum;
            if (idx_q == LastIdx) begin
               state_d = StDone;
               ovf_d   = sum_ovf;
               res_d   = (SATURATE != 0 && sum_ovf) ? '1 : acc_sum[DATA_W-1:0];
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StFetchA;
            end
         end
         StDone: begin
            comp_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Losing the compute qualifier mid-operation abandons it without touching the result.
      if (!mode_compute && (state_q == StFetchA || state_q == StFetchB || state_q == StMac)) begin
         state_d = StIdle;
         acc_d   = '0;
         idx_d   = idx_q;
         a_d     = a_q;
         res_d   = res_q;
         ovf_d   = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign comp_result = res_q;
   assign comp_ovf    = ovf_q;

endmodule

// File: doc/dot8_compute_engine.md
Name: dot8_compute_engine

Overview:
- Compute-side responder to the matrix controller's compute handshake.
- On `comp_start`, reads the A vector (addresses 0-7) and the B vector (addresses 8-15) from the shared 16x8 operand memory through its read port, and accumulates the unsigned dot product.
- Returns an 8-bit result with a one-cycle `comp_done` pulse.
- Sits between the controller and the operand memory read port.

Parameters:
- DATA_W, 8, operand and result width
- N_ELEM, 8, elements per vector
- ADDR_W, 4, memory address width
- B_BASE, 8, base address of the B vector
- SATURATE, 1, 1 = clamp result to all-ones on overflow, 0 = truncate to the low DATA_W bits

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- mode_compute  in  1  controller compute-mode qualifier; must stay high during an operation
- comp_start  in  1  single-cycle start request
- mem_rd_en  out  1  read strobe to operand memory
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data; valid the cycle after addr/en are presented (1-cycle synchronous read)
- busy  out  1  high from the first fetch cycle through the DONE cycle
- comp_done  out  1  one-cycle completion pulse
- comp_result  out  DATA_W  result; held until the next completed operation
- comp_ovf  out  1  accumulator exceeded 2^DATA_W-1 on the last operation; held with the result

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; elem index 0; acc 0; A register 0.
  - Outputs: mem_rd_en 0, mem_rd_addr 0, busy 0, comp_done 0, comp_result 0, comp_ovf 0.
  - Reset asserted mid-operation aborts the operation immediately; no comp_done.
- Accumulator width: 2*DATA_W + clog2(N_ELEM) = 19 bits, unsigned. Each product is DATA_W x DATA_W -> 2*DATA_W bits, zero-extended before the add. The accumulator never wraps.
- FSM states:
  - IDLE: mem_rd_en 0, addr 0. If comp_start and mode_compute are both high -> FETCH_A, with acc, index and A register cleared. comp_start with mode_compute low is ignored.
  - FETCH_A: mem_rd_en 1, addr = index -> FETCH_B.
  - FETCH_B: mem_rd_en 1, addr = B_BASE + index; capture mem_rd_data into the A register -> MAC.
  - MAC: mem_rd_en 0; acc <= acc + A*mem_rd_data.
    - If index == N_ELEM-1 -> DONE.
    - Otherwise index+1 -> FETCH_A.
  - DONE: comp_done 1 for exactly this cycle -> IDLE.
    - comp_result and comp_ovf are registered on the MAC->DONE edge.
    - comp_ovf = (acc_final > 2^DATA_W-1).
    - comp_result = SATURATE ? (ovf ? all-ones : acc[DATA_W-1:0]) : acc[DATA_W-1:0].
- Timing: if comp_start is sampled at edge E0, FETCH_A occupies cycle 1 after E0 and each element takes 3 cycles. comp_done is high during cycle 25 after E0. busy is high during cycles 1-25.
- Address sequence: 0, 8, 1, 9, ... 7, 15.
- comp_start while busy (any state other than IDLE, including DONE): ignored, with no restart and no effect on the result.
- mode_compute low in FETCH_A, FETCH_B or MAC: abort to IDLE on that edge. Acc is cleared; comp_done, comp_result and comp_ovf are unchanged; busy goes 0 in the next cycle.
- mode_compute falling in the DONE cycle: the pulse still completes.
- A new comp_start is accepted in the cycle right after DONE (IDLE), giving a back-to-back operation.

Test Plan:
- A=1..8, B=all 1, start -> address order 0,8,1,9..7,15; comp_done only in cycle 25; comp_result 0x24, comp_ovf 0.
- A=all 2, B=all 3 -> comp_result 0x30, comp_ovf 0. Then a back-to-back start in the cycle after DONE with A=B=all 0 -> comp_result 0x00 at its cycle 25.
- A=B=all 0xFF, SATURATE=1 -> comp_result 0xFF, comp_ovf 1. SATURATE=0 instance -> comp_result 0x08, comp_ovf 1.
- comp_start re-pulsed in cycles 5 and 25 of an operation -> exactly one comp_done (cycle 25), result unaffected, busy 0 in cycle 26.
- mode_compute dropped in cycle 10 -> no comp_done, busy 0 in the following cycle, previous result held. A fresh start then yields the correct result 25 cycles later.
- rst_n low in cycle 12 of an operation -> all outputs at reset values next cycle, no comp_done. A start after reset is released completes normally.
